// File: rtl/des_encrypt_iter.sv
// des_encrypt_iter: iterative DES encryption core, one Feistel round per clock.
// Build macro DES_IO_PERM_EN: when defined, data_out is IP^-1({R16,L16}),
// i.e. standard ciphertext. When undefined, data_out is the raw {R16,L16}
// pre-output, which is the decrypt block's input convention.
// key is the post-PC-1 key: C0 = key[27:0], D0 = key[55:28].
module des_encrypt_iter #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [55:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned HKEY_W = 28;
  localparam int unsigned SUB_W  = 48;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS - 1);

  // Tables use FIPS 46-3 numbering: position 1 is the MSB of the source word.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // S-boxes: entry [box*4 + row], 16 nibbles per row, column 0 in the top nibble.
  localparam logic [63:0] SB [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  // Initial permutation, applied to data_in in every build.
  function automatic logic [BLK_W-1:0] ip(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
    return y;
  endfunction

`ifdef DES_IO_PERM_EN
  localparam int IPINV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  // Final permutation for standard ciphertext output.
  function automatic logic [BLK_W-1:0] ip_inv(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IPINV_T[j])];
    return y;
  endfunction
`endif

  // E expansion of the right half, 32 -> 48 bits.
  function automatic logic [SUB_W-1:0] expansion(input logic [HALF_W-1:0] x);
    logic [SUB_W-1:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
    return y;
  endfunction

  // Eight S-box lookups, 48 -> 32 bits; row = outer bits, column = inner four.
  function automatic logic [HALF_W-1:0] s_function(input logic [SUB_W-1:0] x);
    logic [HALF_W-1:0] y;
    logic [5:0]        six;
    logic [63:0]       row;
    y = '0;
    for (int n = 0; n < 8; n++) begin
      six = x[6'(47 - 6 * n) -: 6];
      row = SB[{3'(n), six[5], six[0]}];
      y[5'(31 - 4 * n) -: 4] = row[{~six[4:1], 2'b00} +: 4];
    end
    return y;
  endfunction

  // P permutation after the S-boxes.
  function automatic logic [HALF_W-1:0] p_post_sf(input logic [HALF_W-1:0] x);
    logic [HALF_W-1:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
    return y;
  endfunction

  // PC-2 selection of the round key from {C,D}, C in the upper half.
  function automatic logic [SUB_W-1:0] p_key2(input logic [2*HKEY_W-1:0] x);
    logic [SUB_W-1:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   l_q, l_d, r_q, r_d;
  logic [HKEY_W-1:0]   c_q, c_d, d_q, d_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BLK_W-1:0]    data_out_q, data_out_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                rot1;
  logic [HKEY_W-1:0]   c_rot, d_rot;
  logic [SUB_W-1:0]    round_key;
  logic [HALF_W-1:0]   f_out, r_new;
  logic [BLK_W-1:0]    pre_out, result;

  // One Feistel round on the current state, plus the output form of its result.
  always_comb begin
    rot1 = cnt_q inside {4'd0, 4'd1, 4'd8, 4'd15};
    if (rot1) begin
      c_rot = {c_q[26:0], c_q[27]};
      d_rot = {d_q[26:0], d_q[27]};
    end else begin
      c_rot = {c_q[25:0], c_q[27:26]};
      d_rot = {d_q[25:0], d_q[27:26]};
    end
    round_key = p_key2({c_rot, d_rot});
    f_out     = p_post_sf(s_function(expansion(r_q) ^ round_key));
    r_new     = l_q ^ f_out;
    pre_out   = {r_new, r_q};
`ifdef DES_IO_PERM_EN
    result    = ip_inv(pre_out);
`else
    result    = pre_out;
`endif
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = ip(data_in);
          c_d        = key[27:0];
          d_d        = key[55:28];
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        l_d   = r_q;
        r_d   = r_new;
        c_d   = c_rot;
        d_d   = d_rot;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_RND) begin
          data_out_d  = result;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;

endmodule
